conv_3x3_sched: RTL and testbench



---
 rtl/conv_sched_pkg.sv | 10 +
 rtl/conv_win_shift.sv | 34 +++
 rtl/conv_3x3_sched.sv | 175 +++++++++++++++++
 tb/tb_conv_3x3_sched.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared state encoding and sizing constants for the 3x3 convolution sequencer.
package conv_sched_pkg;
    localparam int K     = 3;
    localparam int TAPS  = 9;
    localparam int PIX_W = 8;

    typedef enum logic [2:0] {
        IDLE, LOAD_W, FILL, SHIFT, WAIT, CALC, EMIT, DONE
    } state_t;
endpackage

// File: rtl/conv_win_shift.sv
// Column staging plus 3x3 window register; a completed column shifts in from the right.
module conv_win_shift
    import conv_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_en,
    input  logic                  commit,
    input  logic [PIX_W-1:0]      pix,
    output logic [TAPS*PIX_W-1:0] win_data
);
    logic [K-1:0][PIX_W-1:0] stg, col_nxt;

    // Pixels of a column arrive top to bottom; the newest lands in the bottom slot.
    assign col_nxt = {pix, stg[K-1:1]};

    always_ff @(posedge clk) begin
        if (rst)           stg <= '0;
        else if (shift_en) stg <= col_nxt;
    end

    for (genvar r = 0; r < K; r++) begin : g_row
        logic [K-1:0][PIX_W-1:0] row_q;

        always_ff @(posedge clk) begin
            if (rst)
                row_q <= '0;
            else if (shift_en && commit)
                row_q <= {col_nxt[r], row_q[K-1:1]};
        end

        assign win_data[r*K*PIX_W +: K*PIX_W] = row_q;
    end
endmodule

// File: rtl/conv_3x3_sched.sv
// Sequencer for a 3x3 valid convolution over a single-port pixel SRAM.
// Optional CONV_SCHED_PERF_EN adds stall_cnt, a saturating count of output stall cycles.
module conv_3x3_sched
    import conv_sched_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  wgt_valid,
    input  logic [PIX_W-1:0]      wgt_data,
    output logic                  wgt_ready,
    output logic                  pix_rd,
    output logic [ADDR_W-1:0]     pix_addr,
    input  logic [PIX_W-1:0]      pix_data,
    output logic [TAPS*PIX_W-1:0] win_data,
    output logic [TAPS*PIX_W-1:0] win_weight,
    input  logic [PIX_W-1:0]      conv_ans,
    output logic                  out_valid,
    output logic [PIX_W-1:0]      out_data,
    input  logic                  out_ready
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] COL_BACK = ADDR_W'(2*IMG_W - 1);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 3);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 3);
    localparam logic [1:0]        SEL_LAST = 2'(K - 1);

    state_t                     state;
    logic [3:0]                 wcnt;
    logic [1:0]                 rsel, csel;
    logic [ADDR_W-1:0]          orow, ocol, rowbase;
    logic [TAPS-1:0][PIX_W-1:0] wgt;
    logic                       cap, cap_cmt;

    assign win_weight = wgt;

    conv_win_shift u_win (
        .clk      (clk),
        .rst      (rst),
        .shift_en (cap),
        .commit   (cap_cmt),
        .pix      (pix_data),
        .win_data (win_data)
    );

    // SRAM data lags the strobe by one cycle; the last row of a column commits it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap     <= 1'b0;
            cap_cmt <= 1'b0;
        end else begin
            cap     <= pix_rd;
            cap_cmt <= pix_rd && (rsel == SEL_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            wgt_ready <= 1'b0;
            pix_rd    <= 1'b0;
            pix_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            wcnt      <= '0;
            rsel      <= '0;
            csel      <= '0;
            orow      <= '0;
            ocol      <= '0;
            rowbase   <= '0;
            wgt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state     <= LOAD_W;
                    busy      <= 1'b1;
                    wgt_ready <= 1'b1;
                    wcnt      <= '0;
                end
                LOAD_W: if (wgt_valid && wgt_ready) begin
                    wgt[wcnt] <= wgt_data;
                    if (wcnt == 4'(TAPS - 1)) begin
                        wgt_ready <= 1'b0;
                        orow      <= '0;
                        ocol      <= '0;
                        rowbase   <= '0;
                        pix_addr  <= '0;
                        pix_rd    <= 1'b1;
                        rsel      <= '0;
                        csel      <= '0;
                        state     <= FILL;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                // Column-major walk: down a column, then back to the top of the next one.
                FILL: if (rsel == SEL_LAST) begin
                    rsel <= '0;
                    if (csel == SEL_LAST) begin
                        csel   <= '0;
                        pix_rd <= 1'b0;
                        state  <= WAIT;
                    end else begin
                        csel     <= csel + 2'd1;
                        pix_addr <= pix_addr - COL_BACK;
                    end
                end else begin
                    rsel     <= rsel + 2'd1;
                    pix_addr <= pix_addr + ROW_STEP;
                end
                SHIFT: if (rsel == SEL_LAST) begin
                    rsel   <= '0;
                    pix_rd <= 1'b0;
                    state  <= WAIT;
                end else begin
                    rsel     <= rsel + 2'd1;
                    pix_addr <= pix_addr + ROW_STEP;
                end
                WAIT: state <= CALC;
                CALC: begin
                    out_data  <= conv_ans;
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (ocol < COL_LAST) begin
                        ocol     <= ocol + 1'b1;
                        pix_addr <= rowbase + ocol + ADDR_W'(3);
                        pix_rd   <= 1'b1;
                        state    <= SHIFT;
                    end else if (orow < ROW_LAST) begin
                        orow     <= orow + 1'b1;
                        ocol     <= '0;
                        rowbase  <= rowbase + ROW_STEP;
                        pix_addr <= rowbase + ROW_STEP;
                        pix_rd   <= 1'b1;
                        csel     <= '0;
                        state    <= FILL;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONV_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start))
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_conv_3x3_sched.sv
// Directed bench for conv_3x3_sched: 8x8 map with pix(r,c)=8r+c, tap-4 stub datapath, plus a 3x3 instance.
module tb_conv_3x3_sched;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic        busy, done, wgt_ready, pix_rd, out_valid;
    logic        wgt_valid = 1'b0, out_ready = 1'b1;
    logic [7:0]  wgt_data = '0, pix_data = '0, out_data, conv_ans;
    logic [5:0]  pix_addr;
    logic [71:0] win_data, win_weight;

    logic        start3 = 1'b0, busy3, done3, wgt_ready3, pix_rd3, out_valid3;
    logic [3:0]  pix_addr3;
    logic [7:0]  pix_data3 = '0, out_data3, conv_ans3;
    logic [71:0] win_data3, win_weight3;
`ifdef CONV_SCHED_PERF_EN
    logic [15:0] stall_cnt, stall_cnt3;
`endif

    int         n_cmp = 0, n_bad = 0, cyc = 0, c0 = 0;
    int         dcnt = 0, dcyc = 0, res3 = 0, dn3 = 0;
    logic       vprev = 1'b0;
    bit         log_en = 1'b0;
    logic [7:0] exp_q[$];
    int         hs_q[$], vr_q[$];
    logic [5:0] alog[$];
    int         exp_addr[12] = '{0, 8, 16, 1, 9, 17, 2, 10, 18, 3, 11, 19};

    assign conv_ans  = win_data[39:32];
    assign conv_ans3 = win_data3[39:32];

    conv_3x3_sched #(.IMG_W(8), .IMG_H(8), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .wgt_valid(wgt_valid), .wgt_data(wgt_data), .wgt_ready(wgt_ready),
        .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_data(pix_data),
        .win_data(win_data), .win_weight(win_weight), .conv_ans(conv_ans),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef CONV_SCHED_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    conv_3x3_sched #(.IMG_W(3), .IMG_H(3), .ADDR_W(4)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
        .wgt_valid(1'b1), .wgt_data(8'd7), .wgt_ready(wgt_ready3),
        .pix_rd(pix_rd3), .pix_addr(pix_addr3), .pix_data(pix_data3),
        .win_data(win_data3), .win_weight(win_weight3), .conv_ans(conv_ans3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ready(1'b1)
`ifdef CONV_SCHED_PERF_EN
        , .stall_cnt(stall_cnt3)
`endif
    );

    always #5 clk = ~clk;

    // Pixel SRAMs: value equals address, so 8x8 gives 8r+c and 3x3 gives tap 4 = 4.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        pix_data  <= pix_rd  ? 8'(pix_addr)  : 8'hEE;
        pix_data3 <= pix_rd3 ? 8'(pix_addr3) : 8'hEE;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !vprev) vr_q.push_back(cyc);
            if (out_valid && out_ready) begin
                hs_q.push_back(cyc);
                if (exp_q.size() == 0) chk("sb_underflow", 72'(exp_q.size()), 72'd1);
                else                   chk("result", 72'(out_data), 72'(exp_q.pop_front()));
            end
            if (done) begin
                dcnt <= dcnt + 1;
                dcyc <= cyc;
            end
            if (log_en && pix_rd && alog.size() < 12) alog.push_back(pix_addr);
        end
        vprev <= out_valid;
        if (out_valid3) res3 <= res3 + 1;
        if (done3)      dn3  <= dn3 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input int gap);
        for (int i = 1; i <= 9; i++) begin
            int n;
            bit acc;
            n = 0;
            acc = 1'b0;
            wgt_valid = 1'b1;
            wgt_data  = 8'(i);
            do begin
                @(negedge clk);
                acc = wgt_ready;
                tick();
                n++;
            end while (!acc && n < 60);
            if (!acc) chk("wgt_accept_timeout", 72'(acc), 72'd1);
            wgt_valid = 1'b0;
            if (i < 9) repeat (gap) tick();
        end
    endtask

    task automatic begin_run(input int gap, input int lat);
        int n;
        n = 0;
        hs_q.delete();
        vr_q.delete();
        alog.delete();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                exp_q.push_back(8'(8*(r+1) + c + 1));
        tick();
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
        load_w(gap);
        do begin @(negedge clk); n++; end while (!out_valid && n < 300);
        chk("first_valid_latency", 72'(cyc - c0), 72'(lat));
    endtask

    task automatic end_run(input int d0);
        int n;
        n = 0;
        while (dcnt == d0 && n < 3000) begin tick(); n++; end
        repeat (5) tick();
        chk("done_pulses", 72'(dcnt - d0), 72'd1);
        chk("result_count", 72'(hs_q.size()), 72'd36);
        chk("sb_drained", 72'(exp_q.size()), 72'd0);
        chk("done_after_last_hs", 72'(dcyc - hs_q[$]), 72'd1);
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int d0, n;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_done", 72'(done), 72'd0);
        chk("rst_wgt_ready", 72'(wgt_ready), 72'd0);
        chk("rst_pix_rd", 72'(pix_rd), 72'd0);
        chk("rst_out_valid", 72'(out_valid), 72'd0);
        chk("rst_pix_addr", 72'(pix_addr), 72'd0);
        chk("rst_out_data", 72'(out_data), 72'd0);
        chk("rst_win_data", win_data, 72'd0);
        chk("rst_win_weight", win_weight, 72'd0);
        tick();
        rst = 1'b0;

        // Run A: gapless weights, free-flowing sink, start pulse while busy.
        log_en = 1'b1;
        d0 = dcnt;
        begin_run(0, 21);
        chk("first_window", win_data, 72'h121110_0A0908_020100);
        chk("weights", win_weight, 72'h090807060504030201);
        pulse_start();
        end_run(d0);
        log_en = 1'b0;
        for (int i = 0; i < 12; i++)
            chk($sformatf("pix_addr_%0d", i), 72'(alog[i]), 72'(exp_addr[i]));
        chk("spacing_in_row", 72'(vr_q[1] - vr_q[0]), 72'd6);
        chk("spacing_row_wrap", 72'(vr_q[6] - vr_q[5]), 72'd12);

        // Run B: two-cycle weight gaps and a 5-cycle stall on result 3.
        d0 = dcnt;
        begin_run(2, 37);
        chk("weights_gapped", win_weight, 72'h090807060504030201);
        n = 0;
        while (hs_q.size() < 2 && n < 300) begin @(posedge clk); n++; end
        #1 out_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 100);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_valid", 72'(out_valid), 72'd1);
            chk("stall_data", 72'(out_data), 72'd11);
            chk("stall_no_rd", 72'(pix_rd), 72'd0);
        end
        tick();
        out_ready = 1'b1;
        end_run(d0);
        chk("resume_spacing", 72'(vr_q[3] - hs_q[2]), 72'd6);
`ifdef CONV_SCHED_PERF_EN
        chk("stall_cnt", 72'(stall_cnt), 72'd5);
`endif

        // Run C: reset during the second FILL, then a clean rerun.
        d0 = dcnt;
        begin_run(0, 21);
        n = 0;
        while (hs_q.size() < 6 && n < 300) begin @(posedge clk); n++; end
        chk("row0_results", 72'(hs_q.size()), 72'd6);
        #1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("abort_busy", 72'(busy), 72'd0);
        chk("abort_out_valid", 72'(out_valid), 72'd0);
        chk("abort_pix_rd", 72'(pix_rd), 72'd0);
        chk("abort_win_data", win_data, 72'd0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        repeat (10) tick();
        chk("abort_no_done", 72'(dcnt - d0), 72'd0);
        d0 = dcnt;
        begin_run(0, 21);
        pulse_start();
        end_run(d0);

        // Run D: 3x3 map yields a single window.
        tick();
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid3 && n < 200);
        chk("tiny_result", 72'(out_data3), 72'd4);
        @(negedge clk);
        chk("tiny_done", 72'(done3), 72'd1);
        @(negedge clk);
        chk("tiny_done_pulse", 72'(done3), 72'd0);
        chk("tiny_idle", 72'(busy3), 72'd0);
        repeat (10) tick();
        chk("tiny_count", 72'(res3), 72'd1);
        chk("tiny_done_count", 72'(dn3), 72'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
